// File: rtl/tt_sweep_capture_pkg.sv
// Shared types and sizes for the 4-input truth-table sweep reader.
package tt_pkg;

  localparam int N_IN = 4;
  localparam int TT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [TT_W-1:0] tt_t;

endpackage

// File: rtl/tt_sweep_capture_if.sv
// Request/response bundle between a sweep requester and tt_sweep_capture.
interface tt_sweep_capture_if;
  import tt_pkg::*;

  logic            req_valid;
  logic            req_ready;
  tt_t             exp_tt;
  logic            resp_valid;
  logic            resp_ready;
  tt_t             tt;
  logic            match;
  logic [N_IN-1:0] first_mis;
  logic [4:0]      ones;

  // Requester side: issues sweeps and consumes results.
  modport master (
    output req_valid, exp_tt, resp_ready,
    input  req_ready, resp_valid, tt, match, first_mis, ones
  );

  // Sweep engine side.
  modport slave (
    input  req_valid, exp_tt, resp_ready,
    output req_ready, resp_valid, tt, match, first_mis, ones
  );

endinterface

// File: rtl/tt_sweep_capture_popcount16.sv
// Combinational 16-bit population count, shared with NPN-class tooling.
module tt_popcount16
  import tt_pkg::*;
(
  input  tt_t        din,
  output logic [4:0] cnt
);

  // Sum the set bits of the table.
  always_comb begin
    cnt = 5'd0;
    for (int i = 0; i < TT_W; i++) begin
      cnt = cnt + {4'd0, din[i]};
    end
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// Sequential truth-table reader: walks all 16 input vectors through a
// 4-input cell, captures its output and reports compare / onset results.
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  tt_sweep_capture_if.slave  bus,
  output logic [N_IN-1:0]    probe_x,
  input  logic               probe_y
);

  localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST_IDX = 4'd15;

  state_t          state_r;
  state_t          state_s;
  logic [N_IN-1:0] idx_r;
  logic [3:0]      cnt_r;
  tt_t             exp_r;
  tt_t             tt_r;
  tt_t             tt_next_s;
  tt_t             diff_s;
  logic            match_r;
  logic            match_s;
  logic [N_IN-1:0] first_mis_r;
  logic [N_IN-1:0] first_mis_s;
  logic [4:0]      ones_r;
  logic [4:0]      ones_s;
  logic            req_ready_r;
  logic            resp_valid_r;
  logic            accept_s;
  logic            sample_s;
  logic            last_s;
  logic            resp_hs_s;

  // State register; reset aborts any sweep or pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      req_ready_r  <= (state_s == IDLE);
      resp_valid_r <= (state_s == DONE);
    end
  end

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = accept_s  ? SWEEP : IDLE;
      SWEEP:   state_s = last_s    ? DONE  : SWEEP;
      DONE:    state_s = resp_hs_s ? IDLE  : DONE;
      default: state_s = IDLE;
    endcase
  end

  // Control strobes decoded from the current state and handshakes.
  always_comb begin
    accept_s  = req_ready_r & bus.req_valid;
    resp_hs_s = resp_valid_r & bus.resp_ready;
    if (state_r == SWEEP) begin
      sample_s = (cnt_r == SETTLE_C);
    end else begin
      sample_s = 1'b0;
    end
    last_s = sample_s & (idx_r == LAST_IDX);
  end

  // Table with this cycle's sample merged in, plus compare results on it.
  // probe_y only enters on the sample cycle so X elsewhere stays out.
  always_comb begin
    tt_next_s = tt_r;
    if (sample_s) begin
      tt_next_s[idx_r] = probe_y;
    end else begin
      tt_next_s = tt_r;
    end
    diff_s      = tt_next_s ^ exp_r;
    match_s     = (diff_s == {TT_W{1'b0}});
    first_mis_s = 4'd0;
    // Scan high to low so the lowest differing index wins.
    for (int i = TT_W - 1; i >= 0; i--) begin
      first_mis_s = diff_s[i] ? N_IN'(i) : first_mis_s;
    end
  end

  tt_popcount16 u_popcount (
    .din (tt_next_s),
    .cnt (ones_s)
  );

  // Sweep datapath: vector index, settle counter, captured table, results.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_r       <= 16'd0;
      idx_r       <= 4'd0;
      cnt_r       <= 4'd0;
      tt_r        <= 16'd0;
      match_r     <= 1'b0;
      first_mis_r <= 4'd0;
      ones_r      <= 5'd0;
    end else if (accept_s) begin
      exp_r <= bus.exp_tt;
      idx_r <= 4'd0;
      cnt_r <= 4'd0;
      tt_r  <= 16'd0;
    end else if (sample_s) begin
      tt_r  <= tt_next_s;
      cnt_r <= 4'd0;
      // After vector 15 this returns the probe to 0 for DONE/IDLE.
      idx_r <= idx_r + 4'd1;
      if (last_s) begin
        match_r     <= match_s;
        first_mis_r <= first_mis_s;
        ones_r      <= ones_s;
      end else begin
        match_r <= match_r;
      end
    end else if (state_r == SWEEP) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign probe_x        = idx_r;
  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.tt         = tt_r;
  assign bus.match      = match_r;
  assign bus.first_mis  = first_mis_r;
  assign bus.ones       = ones_r;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: three instances (SETTLE 0, 1, 3) share one
// request/response stream, each probing its own copy of a table-driven cell.
module tb_tt_sweep_capture;
  import tt_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic req_valid;
  logic resp_ready;
  tt_t  exp_tt;
  tt_t  cell_tt;
  logic reg_mode;

  logic [3:0] px [3];
  logic       py [3];
  logic       yr [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  tt_sweep_capture_if bus0 ();
  tt_sweep_capture_if bus1 ();
  tt_sweep_capture_if bus3 ();

  assign bus0.req_valid = req_valid;  assign bus0.exp_tt = exp_tt;  assign bus0.resp_ready = resp_ready;
  assign bus1.req_valid = req_valid;  assign bus1.exp_tt = exp_tt;  assign bus1.resp_ready = resp_ready;
  assign bus3.req_valid = req_valid;  assign bus3.exp_tt = exp_tt;  assign bus3.resp_ready = resp_ready;

  tt_sweep_capture #(.SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0), .probe_x(px[0]), .probe_y(py[0]));
  tt_sweep_capture #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .probe_x(px[1]), .probe_y(py[1]));
  tt_sweep_capture #(.SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3), .probe_x(px[2]), .probe_y(py[2]));

  tt_t        o_tt    [3];
  logic       o_match [3];
  logic       o_rr    [3];
  logic       o_rv    [3];
  logic [3:0] o_fm    [3];
  logic [4:0] o_ones  [3];

  // Gather the three instances' outputs into indexable arrays.
  always_comb begin
    o_tt[0] = bus0.tt;  o_match[0] = bus0.match;  o_rr[0] = bus0.req_ready;
    o_rv[0] = bus0.resp_valid;  o_fm[0] = bus0.first_mis;  o_ones[0] = bus0.ones;
    o_tt[1] = bus1.tt;  o_match[1] = bus1.match;  o_rr[1] = bus1.req_ready;
    o_rv[1] = bus1.resp_valid;  o_fm[1] = bus1.first_mis;  o_ones[1] = bus1.ones;
    o_tt[2] = bus3.tt;  o_match[2] = bus3.match;  o_rr[2] = bus3.req_ready;
    o_rv[2] = bus3.resp_valid;  o_fm[2] = bus3.first_mis;  o_ones[2] = bus3.ones;
  end

  // Cell under test: combinational lookup, or the same lookup behind a flop.
  always_comb begin
    for (int d = 0; d < 3; d++) begin
      py[d] = reg_mode ? yr[d] : cell_tt[px[d]];
    end
  end

  // Edge counter and the registered-cell flop.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 3; d++) begin
      yr[d] <= cell_tt[px[d]];
    end
  end

  function automatic int settle_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  // Table a sweep should capture. A registered cell presents f() of the
  // vector driven one cycle before the sample: the same vector when each
  // vector is held 2+ cycles, otherwise the previous one (idle probe is 0).
  function automatic tt_t model_tt(input tt_t f, input logic regd, input int s);
    tt_t r;
    int  src;
    for (int i = 0; i < 16; i++) begin
      src = i;
      if (regd && s == 0 && i > 0) src = i - 1;
      r[i] = f[src];
    end
    return r;
  endfunction

  function automatic int model_fm(input tt_t t, input tt_t e);
    for (int i = 0; i < 16; i++) begin
      if (t[i] != e[i]) return i;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, expv);
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_req_ready"}, d, 32'(o_rr[d]), 32'd0);
      chk({tag, "_resp_valid"}, d, 32'(o_rv[d]), 32'd0);
      chk({tag, "_probe_x"}, d, 32'(px[d]), 32'd0);
      chk({tag, "_tt"}, d, 32'(o_tt[d]), 32'd0);
      chk({tag, "_match"}, d, 32'(o_match[d]), 32'd0);
      chk({tag, "_first_mis"}, d, 32'(o_fm[d]), 32'd0);
      chk({tag, "_ones"}, d, 32'(o_ones[d]), 32'd0);
    end
  endtask

  // Issue one sweep on all instances, check latency, results, backpressure
  // for `hold` cycles, then release and check the return to IDLE.
  task automatic run_sweep(input tt_t f, input logic regd, input tt_t e, input int hold);
    int  hs;
    int  rise [3];
    bit  done [3];
    int  n;
    tt_t mt;
    @(negedge clk);
    cell_tt    = f;
    reg_mode   = regd;
    exp_tt     = e;
    req_valid  = 1'b1;
    resp_ready = 1'b0;
    for (int d = 0; d < 3; d++) chk("idle_req_ready", d, 32'(o_rr[d]), 32'd1);
    hs = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    exp_tt    = ~e;
    for (int d = 0; d < 3; d++) begin
      chk("first_probe_x", d, 32'(px[d]), 32'd0);
      chk("sweep_req_ready", d, 32'(o_rr[d]), 32'd0);
      done[d] = 1'b0;
      rise[d] = -1;
    end
    n = 0;
    while (n < 300) begin
      for (int d = 0; d < 3; d++) begin
        if (!done[d] && o_rv[d] === 1'b1) begin
          done[d] = 1'b1;
          rise[d] = cyc;
        end
      end
      if (done[0] && done[1] && done[2]) break;
      req_valid = 1'($urandom_range(0, 1));
      exp_tt    = tt_t'($urandom);
      @(negedge clk);
      n++;
    end
    for (int d = 0; d < 3; d++) begin
      mt = model_tt(f, regd, settle_of(d));
      chk("resp_seen", d, 32'(done[d]), 32'd1);
      // resp_valid shows after the edge 16*(SETTLE+1) edges past the handshake.
      chk("latency", d, 32'(rise[d] - hs), 32'(16 * (settle_of(d) + 1)));
      chk("tt", d, 32'(o_tt[d]), 32'(mt));
      chk("match", d, 32'(o_match[d]), 32'(mt == e));
      chk("first_mis", d, 32'(o_fm[d]), 32'(model_fm(mt, e)));
      chk("ones", d, 32'(o_ones[d]), 32'($countones(mt)));
    end
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'($urandom_range(0, 1));
      exp_tt    = tt_t'($urandom);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        mt = model_tt(f, regd, settle_of(d));
        chk("hold_tt", d, 32'(o_tt[d]), 32'(mt));
        chk("hold_first_mis", d, 32'(o_fm[d]), 32'(model_fm(mt, e)));
        chk("hold_req_ready", d, 32'(o_rr[d]), 32'd0);
        chk("hold_resp_valid", d, 32'(o_rv[d]), 32'd1);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("post_resp_req_ready", d, 32'(o_rr[d]), 32'd1);
      chk("post_resp_valid", d, 32'(o_rv[d]), 32'd0);
    end
  endtask

  // Start a sweep, reset when the SETTLE=1 instance drives vector 7.
  task automatic run_reset_abort(input tt_t f);
    int n;
    bit seen [3];
    @(negedge clk);
    cell_tt   = f;
    reg_mode  = 1'b0;
    exp_tt    = f;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (px[1] !== 4'd7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_probe7", 1, 32'(px[1]), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("abort");
    rst = 1'b0;
    for (int d = 0; d < 3; d++) seen[d] = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) seen[d] = seen[d] | (o_rv[d] === 1'b1);
    end
    for (int d = 0; d < 3; d++) chk("no_resp_after_abort", d, 32'(seen[d]), 32'd0);
  endtask

  initial begin
    tt_t f;
    tt_t e;
    rst        = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    exp_tt     = 16'd0;
    cell_tt    = 16'd0;
    reg_mode   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk("req_ready_after_reset", d, 32'(o_rr[d]), 32'd1);

    // AND4, XOR4, OR4 against two expectations, registered AND4.
    run_sweep(16'h8000, 1'b0, 16'h8000, 10);
    run_sweep(16'h6996, 1'b0, 16'h6996, 2);
    run_sweep(16'hFFFE, 1'b0, 16'hFFFF, 1);
    run_sweep(16'hFFFE, 1'b0, 16'h7FFE, 0);
    run_sweep(16'h8000, 1'b1, 16'h8000, 1);

    run_reset_abort(16'hA5C3);
    run_sweep(16'h1234, 1'b0, 16'h1234, 1);

    for (int it = 0; it < 10; it++) begin
      f = tt_t'($urandom);
      if ($urandom_range(0, 1) == 0) e = f;
      else e = f ^ (16'd1 << $urandom_range(0, 15));
      run_sweep(f, 1'($urandom_range(0, 1)), e, int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
